// File: rtl/intr_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
// Shared types and constants for the interrupt sequencer.
//   intr_state_t : sequencer FSM states (RUN, ENTER, SERVICE, EXIT)
//   IVEC_*       : one-hot source encodings used on the controller vector
//   vec_target   : handler address for a given source
// -----------------------------------------------------------------------------
package intr_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      ENTER   = 2'd1,
      SERVICE = 2'd2,
      EXIT    = 2'd3
   } intr_state_t;

   localparam logic [1:0] IVEC_NONE = 2'b00;
   localparam logic [1:0] IVEC_IR0  = 2'b01;
   localparam logic [1:0] IVEC_IR1  = 2'b10;

   // Handler address: source 0 sits at base, source 1 one stride above it.
   function automatic logic [31:0] vec_target(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic        src);
      logic [31:0] addr;
      if (src) begin
         addr = base + stride;
      end else begin
         addr = base;
      end
      return addr;
   endfunction

endpackage

// File: rtl/intr_sequencer.sv
// -----------------------------------------------------------------------------
// intr_sequencer
// CPU-side responder for the two-source interrupt controller. Latches the
// controller's one-cycle vector pulses into pending bits, takes an interrupt
// at an instruction boundary (saving the return PC and redirecting fetch to
// the source's handler), masks the controller while a handler runs, and
// redirects back to the saved PC when the return instruction retires.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ireq              controller request (OR of ivec), not used internally
//   ivec[1:0]         controller vector pulse: bit0 = source 0, bit1 = source 1
//   mask              to controller: 1 = drop new edges
//   ie_set, ie_clr    interrupt-enable set / clear pulses (clear wins)
//   instr_done        an instruction retires this cycle
//   next_pc           PC of the next sequential instruction (with instr_done)
//   iret              retiring instruction is a return-from-interrupt
//   redirect          one-cycle fetch redirect
//   redirect_pc       redirect target
//   stall             fetch hold, identical to redirect
//   in_service        a handler is active (ENTER, SERVICE, EXIT)
//   cause             source being serviced
//   epc               saved return PC
//   cnt0, cnt1        saturating per-source taken counters
// -----------------------------------------------------------------------------
module intr_sequencer
   import intr_pkg::*;
#(
   parameter int          PC_W       = 32,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
   parameter int          CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ireq,
   input  logic [1:0]       ivec,
   output logic             mask,
   input  logic             ie_set,
   input  logic             ie_clr,
   input  logic             instr_done,
   input  logic [PC_W-1:0]  next_pc,
   input  logic             iret,
   output logic             redirect,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             stall,
   output logic             in_service,
   output logic             cause,
   output logic [PC_W-1:0]  epc,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   intr_state_t      state_q, state_d;
   logic [1:0]       pend_q, pend_d;
   logic             ie_q, ie_d;
   logic             cause_q, cause_d;
   logic [PC_W-1:0]  epc_q, epc_d;
   logic             redirect_q, redirect_d;
   logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
   logic             in_service_q, in_service_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic             take_s;
   logic             take_src_s;
   logic [1:0]       pend_clr_s;
   logic             unused_ireq_s;

   // ireq is redundant with ivec; kept on the port list for the controller.
   assign unused_ireq_s = ireq;

   // Next-state decode for the FSM, pending/enable bits and counters.
   always_comb begin
      state_d       = state_q;
      ie_d          = ie_q;
      cause_d       = cause_q;
      epc_d         = epc_q;
      redirect_d    = 1'b0;
      redirect_pc_d = {PC_W{1'b0}};
      cnt0_d        = cnt0_q;
      cnt1_d        = cnt1_q;

      // Takes use registered pend/ie only, so a pulse or ie_clr arriving in
      // the boundary cycle itself does not affect that boundary's decision.
      take_s     = (state_q == RUN) & ie_q & (pend_q != IVEC_NONE) & instr_done;
      take_src_s = ~pend_q[0];

      if (take_s) begin
         pend_clr_s = take_src_s ? IVEC_IR1 : IVEC_IR0;
      end else begin
         pend_clr_s = IVEC_NONE;
      end
      // New pulses are OR'd in after the clear so a same-cycle set wins.
      pend_d = (pend_q & ~pend_clr_s) | ivec;

      if (ie_clr) begin
         ie_d = 1'b0;
      end else if (ie_set) begin
         ie_d = 1'b1;
      end else begin
         ie_d = ie_q;
      end

      case (state_q)
         RUN: begin
            if (take_s) begin
               state_d       = ENTER;
               cause_d       = take_src_s;
               epc_d         = next_pc;
               redirect_d    = 1'b1;
               redirect_pc_d = PC_W'(vec_target(VEC_BASE, VEC_STRIDE, take_src_s));
               if (!take_src_s && !(&cnt0_q)) begin
                  cnt0_d = cnt0_q + CNT_W'(1'b1);
               end else if (take_src_s && !(&cnt1_q)) begin
                  cnt1_d = cnt1_q + CNT_W'(1'b1);
               end else begin
                  cnt0_d = cnt0_q;
                  cnt1_d = cnt1_q;
               end
            end else begin
               state_d = RUN;
            end
         end
         ENTER: begin
            state_d = SERVICE;
         end
         SERVICE: begin
            if (instr_done && iret) begin
               state_d       = EXIT;
               redirect_d    = 1'b1;
               redirect_pc_d = epc_q;
            end else begin
               state_d = SERVICE;
            end
         end
         EXIT: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      in_service_d = (state_d != RUN);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         pend_q        <= 2'b00;
         ie_q          <= 1'b0;
         cause_q       <= 1'b0;
         epc_q         <= {PC_W{1'b0}};
         redirect_q    <= 1'b0;
         redirect_pc_q <= {PC_W{1'b0}};
         in_service_q  <= 1'b0;
         cnt0_q        <= {CNT_W{1'b0}};
         cnt1_q        <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         ie_q          <= ie_d;
         cause_q       <= cause_d;
         epc_q         <= epc_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         in_service_q  <= in_service_d;
         cnt0_q        <= cnt0_d;
         cnt1_q        <= cnt1_d;
      end
   end

   // The controller must stop accepting edges as soon as a handler starts.
   assign mask        = ~ie_q | (state_q != RUN);
   assign redirect    = redirect_q;
   assign stall       = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign in_service  = in_service_q;
   assign cause       = cause_q;
   assign epc         = epc_q;
   assign cnt0        = cnt0_q;
   assign cnt1        = cnt1_q;

endmodule

// File: tb/tb_intr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_intr_sequencer
// Directed scenarios followed by random traffic, every cycle compared with a
// behavioural model of the interrupt sequencing rules.
// -----------------------------------------------------------------------------
module tb_intr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        ireq;
   logic [1:0]  ivec;
   logic        mask;
   logic        ie_set;
   logic        ie_clr;
   logic        instr_done;
   logic [31:0] next_pc;
   logic        iret;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        in_service;
   logic        cause;
   logic [31:0] epc;
   logic [7:0]  cnt0;
   logic [7:0]  cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: handler lifecycle phase 0 idle, 1 entering,
   // 2 in handler, 3 returning.
   bit [1:0]  m_pend;
   bit        m_ie;
   int        m_phase;
   bit        m_cause;
   bit [31:0] m_epc;
   int        m_cnt [2];
   bit        m_redir;
   bit [31:0] m_rpc;

   intr_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .ireq        (ireq),
      .ivec        (ivec),
      .mask        (mask),
      .ie_set      (ie_set),
      .ie_clr      (ie_clr),
      .instr_done  (instr_done),
      .next_pc     (next_pc),
      .iret        (iret),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .in_service  (in_service),
      .cause       (cause),
      .epc         (epc),
      .cnt0        (cnt0),
      .cnt1        (cnt1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit [1:0] v, input bit s, input bit c,
                               input bit d, input bit [31:0] pc, input bit ir);
      bit take;
      int src;
      if (r) begin
         m_pend = 2'b00; m_ie = 1'b0; m_phase = 0; m_cause = 1'b0; m_epc = 32'h0;
         m_cnt[0] = 0; m_cnt[1] = 0; m_redir = 1'b0; m_rpc = 32'h0;
         return;
      end
      take    = (m_phase == 0) && m_ie && (m_pend != 2'b00) && d;
      src     = m_pend[0] ? 0 : 1;
      m_redir = 1'b0;
      if (take) begin
         m_pend[src] = 1'b0;
         m_cause     = (src == 1);
         m_epc       = pc;
         if (m_cnt[src] < 255) m_cnt[src] = m_cnt[src] + 1;
         m_phase = 1;
         m_redir = 1'b1;
         m_rpc   = 32'h100 + 32'(src) * 32'h10;
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (m_phase == 2 && d && ir) begin
         m_phase = 3;
         m_redir = 1'b1;
         m_rpc   = m_epc;
      end else if (m_phase == 3) begin
         m_phase = 0;
      end
      m_pend = m_pend | v;
      if (c) m_ie = 1'b0;
      else if (s) m_ie = 1'b1;
   endtask

   task automatic compare_all();
      check("redirect", redirect, m_redir);
      check("stall", stall, m_redir);
      check("mask", mask, (!m_ie || m_phase != 0));
      check("in_service", in_service, (m_phase != 0));
      check("epc", epc, m_epc);
      check("cnt0", cnt0, m_cnt[0][7:0]);
      check("cnt1", cnt1, m_cnt[1][7:0]);
      if (m_phase != 0) check("cause", cause, m_cause);
      if (m_redir) check("redirect_pc", redirect_pc, m_rpc);
   endtask

   // One clock cycle: drive inputs, clock, advance model, compare.
   task automatic step(input bit r, input bit [1:0] v, input bit s, input bit c,
                       input bit d, input bit [31:0] pc, input bit ir);
      rst = r; ivec = v; ireq = |v; ie_set = s; ie_clr = c;
      instr_done = d; next_pc = pc; iret = ir;
      @(posedge clk);
      model_update(r, v, s, c, d, pc, ir);
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   // SERVICE entry from ENTER, return instruction, EXIT back to RUN.
   task automatic finish_handler();
      idle();
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
      idle();
   endtask

   initial begin
      rst = 1'b1; ivec = 2'b00; ireq = 1'b0; ie_set = 1'b0; ie_clr = 1'b0;
      instr_done = 1'b0; next_pc = 32'h0; iret = 1'b0;

      // Reset values
      step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rst_redirect", redirect, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_mask", mask, 1'b1);
      check("rst_in_service", in_service, 1'b0);
      check("rst_cause", cause, 1'b0);
      check("rst_epc", epc, 32'h0);
      check("rst_redirect_pc", redirect_pc, 32'h0);
      check("rst_cnt0", cnt0, 8'd0);
      check("rst_cnt1", cnt1, 8'd0);

      // Basic take of source 0 with 2-cycle latency
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      repeat (7) idle();
      step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t1_no_early_redirect", redirect, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
      check("t1_redirect", redirect, 1'b1);
      check("t1_rpc", redirect_pc, 32'h100);
      check("t1_cause", cause, 1'b0);
      check("t1_epc", epc, 32'h40);
      check("t1_cnt0", cnt0, 8'd1);
      check("t1_mask", mask, 1'b1);
      idle();
      check("t1_service_no_redirect", redirect, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
      check("t1_exit_rpc", redirect_pc, 32'h40);
      idle();
      check("t1_back_in_run", in_service, 1'b0);
      check("t1_unmasked", mask, 1'b0);

      // Both pending: source 0 first, source 1 after return
      step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
      check("t2_first_rpc", redirect_pc, 32'h100);
      check("t2_first_cause", cause, 1'b0);
      idle();
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
      check("t2_ret_rpc", redirect_pc, 32'h40);
      idle();
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
      check("t2_second_rpc", redirect_pc, 32'h110);
      check("t2_second_cause", cause, 1'b1);
      check("t2_cnt1", cnt1, 8'd1);
      finish_handler();

      // Disabled: request held pending until ie_set
      step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h48, 1'b0);
      check("t3_disabled_no_redirect", redirect, 1'b0);
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h50, 1'b0);
      check("t3_rpc", redirect_pc, 32'h110);
      finish_handler();

      // Same-cycle pulse and boundary; pulse captured during ENTER
      step(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 32'h58, 1'b0);
      check("t4_same_cycle_no_take", redirect, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h60, 1'b0);
      check("t4_take_rpc", redirect_pc, 32'h100);
      step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t4_no_nest", redirect, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
      check("t4_exit_rpc", redirect_pc, 32'h60);
      idle();
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h70, 1'b0);
      check("t4_captured_rpc", redirect_pc, 32'h100);
      check("t4_captured_epc", epc, 32'h70);
      finish_handler();

      // iret in RUN ignored; ie_set with ie_clr leaves ie clear
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h74, 1'b1);
      check("t5_iret_run", redirect, 1'b0);
      check("t5_iret_state", in_service, 1'b0);
      step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("t5_clr_wins", mask, 1'b1);
      step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h78, 1'b0);
      check("t5_no_take", redirect, 1'b0);

      // Reset during SERVICE discards context
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
      idle();
      step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("t6_in_service", in_service, 1'b0);
      check("t6_mask", mask, 1'b1);
      check("t6_cnt0", cnt0, 8'd0);
      check("t6_cnt1", cnt1, 8'd0);
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h84, 1'b0);
      check("t6_pend_cleared", redirect, 1'b0);

      // Counter saturation
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h200 + 32'(i) * 32'h4, 1'b0);
         finish_handler();
      end
      check("t7_cnt0_sat", cnt0, 8'd255);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int          rv;
         bit [1:0]    v;
         bit [31:0]   pc;
         rv = int'($urandom_range(0, 9));
         v  = (rv < 7) ? 2'b00 : 2'(rv - 6);
         pc = $urandom() & 32'hFFFF_FFFC;
         step(($urandom_range(0, 199) == 0),
              v,
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 1) == 1),
              pc,
              ($urandom_range(0, 2) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/intr_sequencer.md
# intr_sequencer

CPU-side responder for the two-source interrupt controller. Captures one-cycle `ireq`/`ivec` pulses into pending bits and drives the controller's `mask` input. At an instruction boundary it saves the return PC, redirects fetch to a per-source vector, holds off further requests while in service, and redirects back to the saved PC when the return instruction retires. It sits between the interrupt controller and the fetch/PC logic of the core.

## Interface
- `PC_W`, default 32: PC width.
- `VEC_BASE`, default 32'h0000_0100: handler address of source 0.
- `VEC_STRIDE`, default 32'h0000_0010: address offset between source handlers.
- `CNT_W`, default 8: width of the per-source taken counters.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `ireq`  in  1  controller request (the OR of `ivec` bits); informational only
- `ivec`  in  2  controller vector: 01 = source 0 edge, 10 = source 1 edge, 00 = none; one-cycle pulse
- `mask`  out  1  to controller; 1 = controller drops new edges
- `ie_set`  in  1  pulse: set interrupt enable (STI)
- `ie_clr`  in  1  pulse: clear interrupt enable (CLI)
- `instr_done`  in  1  an instruction retires this cycle (boundary)
- `next_pc`  in  PC_W  PC of the next sequential instruction, valid with `instr_done`
- `iret`  in  1  the retiring instruction is a return-from-interrupt; qualified by `instr_done`
- `redirect`  out  1  one-cycle fetch redirect
- `redirect_pc`  out  PC_W  target address, valid with `redirect`
- `stall`  out  1  fetch hold; equals `redirect`
- `in_service`  out  1  a handler is active
- `cause`  out  1  source being serviced (0 or 1); valid while `in_service`
- `epc`  out  PC_W  saved return PC
- `cnt0`, `cnt1`  out  CNT_W  saturating count of interrupts taken per source

## Operation
- `pend[1:0]`: set from `ivec[0]`/`ivec[1]` every cycle, in any state. `ivec`=11 sets both bits. A bit is cleared only when its source is taken. Set and clear in the same cycle: set wins.
- `ie`: reset 0. `ie_set` sets it. `ie_clr` clears it. If both pulse together, clear wins.
- `mask` = `~ie | (state != RUN)`. It is a combinational decode of registers.
- FSM states:
  - RUN → ENTER when `ie & (pend != 0) & instr_done`. On that edge:
    - `epc` ← `next_pc`
    - `cause` ← 0 if `pend[0]`, else 1 (source 0 has priority)
    - the chosen `pend` bit is cleared
    - the matching counter increments, saturating at all-ones
  - ENTER → SERVICE unconditionally. During ENTER: `redirect`=1, `redirect_pc` = `VEC_BASE + cause*VEC_STRIDE`, truncated to PC_W.
  - SERVICE → EXIT when `instr_done & iret`.
  - EXIT → RUN unconditionally. During EXIT: `redirect`=1, `redirect_pc` = `epc`.
- `in_service` = 1 in ENTER, SERVICE and EXIT.
- `iret` outside SERVICE is ignored.
- There is no nesting. Edges that reach the controller while `mask`=1 are lost by design.
- A pulse the controller had already registered before `mask` rose is still captured in `pend` and taken after EXIT.

## Timing
- Reset values: state RUN, `pend`=0, `ie`=0, `mask`=1, `redirect`=0, `stall`=0, `redirect_pc`=0, `in_service`=0, `cause`=0, `epc`=0, `cnt0`=`cnt1`=0.
- `ivec` pulse in cycle k → `pend` visible in k+1. The earliest take is `instr_done` in k+1, with `redirect` in k+2 (2 cycles of latency).
- `instr_done` in the same cycle as the `ivec` pulse does not take that pulse; it is taken at the next boundary.
- ENTER and EXIT each last exactly one cycle. `redirect` never stays high for two consecutive cycles of the same kind.
- `ie_clr` in cycle t blocks a take in t+1 onward. A take decided in cycle t itself still proceeds.
- `rst` in any state returns to RUN next cycle with all reset values. Pending and in-service context is discarded.

## Structure
- Package `intr_pkg` holds:
  - state enum `intr_state_t` {RUN, ENTER, SERVICE, EXIT}
  - `IVEC_NONE`=2'b00, `IVEC_IR0`=2'b01, `IVEC_IR1`=2'b10
- No sub-module: this is a single FSM, the pending/enable registers and two counters.

## Test plan
- Reset, then `ie_set`; `ivec`=01 at cycle 10; `instr_done` at 11 with `next_pc`=0x40 → `redirect` at 12, `redirect_pc`=0x100, `cause`=0, `epc`=0x40, `cnt0`=1, `mask`=1.
- Both pending (`ivec`=11) → source 0 taken first at 0x100. After `iret` → `redirect_pc`=0x40, then source 1 taken at 0x110 at the next boundary.
- `ie`=0 with `ivec`=10 → no redirect, `pend[1]`=1. `ie_set` then `instr_done` → redirect to 0x110.
- `ivec`=01 one cycle after entering ENTER → captured. Taken after EXIT, not nested.
- `iret` pulsed in RUN → no redirect, state unchanged. `ie_set`+`ie_clr` together → `ie`=0.
- `rst` asserted during SERVICE → next cycle `in_service`=0, `mask`=1, `pend`=0, counters 0. Run 300 takes of source 0 with `CNT_W`=8 → `cnt0` saturates at 255.
